// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash multi-lane reader: opcodes, lane modes, FSM states.
package spi_flash_pkg;

  localparam logic [7:0] CMD_READ_1 = 8'h0B;
  localparam logic [7:0] CMD_READ_2 = 8'h3B;
  localparam logic [7:0] CMD_READ_4 = 8'h6B;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'd0,
    MODE_DUAL   = 2'd1,
    MODE_QUAD   = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_READ,
    ST_DRAIN
  } state_e;

  // Reserved encoding collapses onto single-lane operation.
  function automatic mode_e norm_mode(input logic [1:0] m);
    return (m == MODE_RSVD) ? MODE_SINGLE : mode_e'(m);
  endfunction

  function automatic logic [7:0] mode_cmd(input mode_e m);
    case (m)
      MODE_DUAL: return CMD_READ_2;
      MODE_QUAD: return CMD_READ_4;
      default:   return CMD_READ_1;
    endcase
  endfunction

  // Index of the final SCK of a byte: 8, 4 or 2 SCK per byte.
  function automatic logic [2:0] mode_last_sck(input mode_e m);
    case (m)
      MODE_DUAL: return 3'd3;
      MODE_QUAD: return 3'd1;
      default:   return 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/spi_flash_lane_shift.sv
// 32-bit command/address output shifter plus 1/2/4-lane input byte assembler.
module spi_flash_lane_shift
  import spi_flash_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] word_i,
  input  logic        shift_i,
  input  logic        cap_i,
  input  logic [1:0]  mode_i,
  input  logic [3:0]  io_i,
  output logic        mosi_o,
  output logic [7:0]  byte_o,
  output logic        last_o,
  output logic        byte_done_o
);

  logic [31:0] sr_q, sr_d;
  logic [7:0]  asm_q, asm_d, asm_nx;
  logic [2:0]  bcnt_q, bcnt_d;
  mode_e       mode;

  assign mode = mode_e'(mode_i);

  // Higher-numbered lanes land in the more significant bit positions.
  always_comb begin
    case (mode)
      MODE_DUAL: asm_nx = {asm_q[5:0], io_i[1:0]};
      MODE_QUAD: asm_nx = {asm_q[3:0], io_i[3:0]};
      default:   asm_nx = {asm_q[6:0], io_i[1]};
    endcase
  end

  assign last_o      = (bcnt_q == mode_last_sck(mode));
  assign byte_done_o = cap_i && last_o;
  assign byte_o      = asm_nx;
  assign mosi_o      = sr_q[31];

  always_comb begin
    sr_d   = sr_q;
    asm_d  = asm_q;
    bcnt_d = bcnt_q;
    if (load_i) begin
      sr_d   = word_i;
      asm_d  = '0;
      bcnt_d = '0;
    end else begin
      if (shift_i) sr_d = {sr_q[30:0], 1'b0};
      if (cap_i) begin
        asm_d  = asm_nx;
        bcnt_d = last_o ? 3'd0 : bcnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q   <= '0;
      asm_q  <= '0;
      bcnt_q <= '0;
    end else begin
      sr_q   <= sr_d;
      asm_q  <= asm_d;
      bcnt_q <= bcnt_d;
    end
  end

endmodule

// File: rtl/spi_flash_mreader.sv
// SPI flash fast-read master: single/dual/quad output read into a one-byte holding register.
module spi_flash_mreader
  import spi_flash_pkg::*;
#(
  parameter int unsigned LEN_W     = 16,
  parameter int unsigned DUMMY_CYC = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [23:0]      addr,
  input  logic [LEN_W-1:0] len,
  input  logic [1:0]       mode,
  input  logic             go,
  output logic             rdy,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             spi_cs_n,
  output logic             spi_clk,
  output logic [3:0]       io_out,
  output logic [3:0]       io_oe,
  input  logic [3:0]       io_in
);

  localparam logic [4:0] DUMMY_LAST = 5'((DUMMY_CYC == 0) ? 0 : DUMMY_CYC - 1);

  state_e           state_q, state_d;
  logic             phase_q, phase_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [LEN_W-1:0] bytes_q, bytes_d;
  mode_e            mode_q, mode_d;
  logic [7:0]       hold_q, hold_d;
  logic             valid_q, valid_d;

  logic       accept, active, cmd_addr, tick_b, stall, shift, cap;
  logic       mosi, last_sck, byte_done;
  logic [7:0] byte_val;

  assign accept   = (state_q == ST_IDLE) && go && (len != '0);
  assign active   = state_q inside {ST_CMD, ST_ADDR, ST_DUMMY, ST_READ};
  assign cmd_addr = state_q inside {ST_CMD, ST_ADDR};
  assign tick_b   = active && phase_q;
  assign shift    = tick_b && cmd_addr;
  assign cap      = tick_b && (state_q == ST_READ);
  // Stall before the byte-completing SCK rises, so the assembler never holds an orphaned byte.
  assign stall    = (state_q == ST_READ) && !phase_q && last_sck && valid_q && !out_ready;

  spi_flash_lane_shift u_shift (
    .clk         (clk),
    .rst         (rst),
    .load_i      (accept),
    .word_i      ({mode_cmd(norm_mode(mode)), addr}),
    .shift_i     (shift),
    .cap_i       (cap),
    .mode_i      (mode_q),
    .io_i        (io_in),
    .mosi_o      (mosi),
    .byte_o      (byte_val),
    .last_o      (last_sck),
    .byte_done_o (byte_done)
  );

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    bytes_d = bytes_q;
    mode_d  = mode_q;
    hold_d  = hold_q;
    valid_d = valid_q;

    if (active && !stall) phase_d = ~phase_q;
    if (tick_b) cnt_d = cnt_q + 5'd1;
    if (valid_q && out_ready) valid_d = 1'b0;
    if (byte_done) begin
      hold_d  = byte_val;
      valid_d = 1'b1;
      bytes_d = bytes_q - LEN_W'(1);
    end

    unique case (state_q)
      ST_IDLE: if (accept) begin
        state_d = ST_CMD;
        phase_d = 1'b0;
        cnt_d   = '0;
        bytes_d = len;
        mode_d  = norm_mode(mode);
      end
      ST_CMD: if (tick_b && cnt_q == 5'd7) begin
        state_d = ST_ADDR;
        cnt_d   = '0;
      end
      ST_ADDR: if (tick_b && cnt_q == 5'd23) begin
        state_d = (DUMMY_CYC == 0) ? ST_READ : ST_DUMMY;
        cnt_d   = '0;
      end
      ST_DUMMY: if (tick_b && cnt_q == DUMMY_LAST) begin
        state_d = ST_READ;
        cnt_d   = '0;
      end
      ST_READ: if (byte_done && bytes_q == LEN_W'(1)) begin
        state_d = ST_DRAIN;
        phase_d = 1'b0;
      end
      ST_DRAIN: if (!valid_q) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      phase_q <= 1'b0;
      cnt_q   <= '0;
      bytes_q <= '0;
      mode_q  <= MODE_SINGLE;
      hold_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      bytes_q <= bytes_d;
      mode_q  <= mode_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
    end
  end

  assign rdy       = (state_q == ST_IDLE);
  assign spi_cs_n  = !active;
  assign spi_clk   = tick_b;
  assign io_oe     = cmd_addr ? 4'b0001 : 4'b0000;
  assign io_out    = {2'b11, 1'b0, cmd_addr && mosi};
  assign out_data  = hold_q;
  assign out_valid = valid_q;

endmodule

// File: doc/spi_flash_mreader.md
SPI_FLASH_MREADER -- requirements
Module: spi_flash_mreader

Interface
REQ-001 Parameter LEN_W, default 16: width of the byte-count input.
REQ-002 Parameter DUMMY_CYC, default 8: number of dummy SCK cycles after the address (range 0..15).
REQ-003 clk  in  1  single system clock; all logic is on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 addr  in  24  flash start byte address, sampled on accepted go.
REQ-006 len  in  LEN_W  number of bytes to read, sampled on accepted go.
REQ-007 mode  in  2  lane mode, sampled on accepted go: 0 = single (0x0B), 1 = dual-output (0x3B), 2 = quad-output (0x6B); 3 is reserved and treated as 0.
REQ-008 go  in  1  start pulse, accepted only when rdy=1 and len!=0.
REQ-009 rdy  out  1  idle, ready for a command.
REQ-010 out_data  out  8  read byte, MSB first from flash.
REQ-011 out_valid  out  1  out_data holds an unconsumed byte.
REQ-012 out_ready  in  1  consumer accepts the byte when out_valid & out_ready.
REQ-013 spi_cs_n, spi_clk  out  1 each  flash chip select and serial clock.
REQ-014 io_out, io_oe  out  4 each  lane drive value and lane output enable (lane 0 = MOSI/IO0).
REQ-015 io_in  in  4  lane input values, already registered in the IOB (io_in[1] = MISO in single mode).

Function
REQ-016 SCK runs at clk/2: phase A drives spi_clk=0 and updates io_out; phase B drives spi_clk=1; io_in is sampled on the clk edge ending phase B.
REQ-017 State machine: IDLE -> CMD (8 SCK, lane 0) -> ADDR (24 SCK, lane 0, MSB first) -> DUMMY (DUMMY_CYC SCK; skipped if 0) -> READ -> DRAIN -> IDLE.
REQ-018 io_oe = 4'b0001 in CMD and ADDR; io_oe = 0 in all other states; io_out[3:2] = 2'b11 during CMD/ADDR to keep WP#/HOLD# inactive.
REQ-019 READ captures 1, 2 or 4 bits per SCK according to mode: 8, 4 or 2 SCK per byte, with higher-numbered lanes forming the more significant bits.
REQ-020 A completed byte loads the single-entry holding register and sets out_valid on the next clk edge.
REQ-021 Backpressure: if a byte completes while the holding register is full and not being consumed that cycle, SCK holds low (phase A) until it is consumed; no bit is lost.
REQ-022 Simultaneous byte completion and consumption loads the new byte with no stall cycle.
REQ-023 The byte counter is LEN_W bits, loaded with len, and decrements per completed byte; READ exits when the count reaches 0.
REQ-024 spi_cs_n is low from the first CMD phase A through the last READ phase B, and high in IDLE and DRAIN.
REQ-025 DRAIN waits until out_valid=0, then goes to IDLE; rdy=1 only in IDLE.
REQ-026 go with len=0, or go while rdy=0, is ignored, with no state change.
REQ-027 Reserved mode 3 behaves exactly as mode 0, using command 0x0B.

Reset
REQ-028 On rst (asynchronous): state=IDLE, spi_cs_n=1, spi_clk=0, io_oe=0, io_out=4'b1100, out_valid=0, out_data=0, rdy=1 from the first clk edge after release.
REQ-029 Reset mid-transfer aborts immediately, with CS deasserted in the same cycle and any held byte discarded.

Structure
REQ-030 Shared package spi_flash_pkg holds the command opcodes (0x0B/0x3B/0x6B), the mode encodings and the state encodings.
REQ-031 One sub-module, spi_flash_lane_shift, is used: a 32-bit command/address shifter plus a 1/2/4-lane input assembler with byte-done output.
REQ-032 No SB_IO is instantiated here; the top level maps io_*/spi_* to IOBs.

Verification
REQ-033 Single read: mode=0, addr=0x123456, len=2, out_ready=1 -> lane 0 carries 0x0B,0x12,0x34,0x56; 8 dummy SCK; model bytes 0xA5,0x3C appear on out_data; rdy returns to 1.
REQ-034 Quad read: mode=2, len=4 -> 2 SCK per byte, io_oe=0 after ADDR, 4 bytes correct, and CS low for exactly 8+24+8+8=48 SCK.
REQ-035 Backpressure: mode=1, len=3, out_ready=0 for 20 clk after the first out_valid -> spi_clk stays low during the stall, all 3 bytes are delivered in order, and no SCK is issued beyond 8+24+8+12.
REQ-036 Ignored go: go with len=0, then go pulsed during a busy transfer -> no CS activity and the transfer is unaffected.
REQ-037 Reset mid-READ: assert rst during byte 2 of len=8 -> spi_cs_n=1 and out_valid=0 in the same cycle; the next command completes normally.
REQ-038 DUMMY_CYC=0 instance: mode=0, len=1 -> READ starts directly after the 24th address SCK.
